// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits that share
// one hex-to-segment decoder. A blanking gap precedes every digit slot, and new
// display data is swapped in only at a frame boundary so a frame is never torn.
module seg7_scan_ctrl #(
  parameter int NUM_DIG   = 4,
  parameter int ON_CYC    = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iEN,
  input  logic                 iLOAD,
  input  logic [4*NUM_DIG-1:0] iDATA,
  input  logic [NUM_DIG-1:0]   iBLANK,
  output logic [3:0]           oDIG,
  output logic [NUM_DIG-1:0]   oSEL_N,
  output logic                 oPEND,
  output logic                 oLOAD_ACK,
  output logic                 oFRAME
);

  localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);

  typedef enum logic {
    stBlank = 1'b0,
    stOn    = 1'b1
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cycCnt;
  logic [IDX_W-1:0]     digIdx;
  logic [IDX_W-1:0]     nextIdx;
  logic                 lastDig;
  logic [4*NUM_DIG-1:0] activeData;
  logic [4*NUM_DIG-1:0] pendData;

  // Nibble k of a packed display value.
  function automatic logic [3:0] nibbleAt(input logic [4*NUM_DIG-1:0] v,
                                          input logic [IDX_W-1:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

  // Active-low enable pattern for digit k, or all off when that digit is masked.
  function automatic logic [NUM_DIG-1:0] selFor(input logic [IDX_W-1:0] k,
                                                input logic blank);
    logic [NUM_DIG-1:0] s;
    s = '1;
    if (!blank) s[k] = 1'b0;
    return s;
  endfunction

  assign lastDig = (digIdx == IDX_LAST);
  assign nextIdx = lastDig ? '0 : digIdx + 1'b1;

  // Scan FSM, load handshake and all registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= stBlank;
      cycCnt     <= '0;
      digIdx     <= '0;
      activeData <= '0;
      pendData   <= '0;
      oDIG       <= '0;
      oSEL_N     <= '1;
      oPEND      <= 1'b0;
      oLOAD_ACK  <= 1'b0;
      oFRAME     <= 1'b0;
    end else begin
      oLOAD_ACK <= 1'b0;
      oFRAME    <= 1'b0;

      // Loads are accepted in any state; the latest one wins.
      if (iLOAD) begin
        pendData <= iDATA;
        oPEND    <= 1'b1;
      end

      if (!iEN) begin
        // Freeze: index, oDIG and active data hold; restart from a full blank.
        state  <= stBlank;
        cycCnt <= '0;
        oSEL_N <= '1;
      end else begin
        case (state)
          stBlank: begin
            if (cycCnt == BLANK_LAST) begin
              state  <= stOn;
              cycCnt <= '0;
              oSEL_N <= selFor(digIdx, iBLANK[digIdx]);
            end else begin
              cycCnt <= cycCnt + 1'b1;
            end
          end
          stOn: begin
            if (cycCnt == ON_LAST) begin
              state  <= stBlank;
              cycCnt <= '0;
              digIdx <= nextIdx;
              oSEL_N <= '1;
              if (lastDig) begin
                // Frame boundary: pending data becomes active, digit 0 bypasses it.
                oFRAME <= 1'b1;
                if (oPEND) begin
                  activeData <= pendData;
                  oLOAD_ACK  <= 1'b1;
                  oDIG       <= pendData[3:0];
                  if (!iLOAD) oPEND <= 1'b0;
                end else begin
                  oDIG <= activeData[3:0];
                end
              end else begin
                oDIG <= nibbleAt(activeData, nextIdx);
              end
            end else begin
              cycCnt <= cycCnt + 1'b1;
              oSEL_N <= selFor(digIdx, iBLANK[digIdx]);
            end
          end
          default: state <= stBlank;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with NUM_DIG=4, ON_CYC=8, BLANK_CYC=2.
// The reference model tracks the position inside a 40-cycle frame and derives
// every expected output from that position arithmetically.
module tb_seg7_scan_ctrl;

  localparam int ND  = 4;
  localparam int ONC = 8;
  localparam int BLC = 2;
  localparam int SLOT  = ONC + BLC;
  localparam int FRAME = ND * SLOT;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iEN;
  logic          iLOAD;
  logic [15:0]   iDATA;
  logic [3:0]    iBLANK;
  logic [3:0]    oDIG;
  logic [3:0]    oSEL_N;
  logic          oPEND;
  logic          oLOAD_ACK;
  logic          oFRAME;

  seg7_scan_ctrl #(.NUM_DIG(ND), .ON_CYC(ONC), .BLANK_CYC(BLC)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iEN       (iEN),
    .iLOAD     (iLOAD),
    .iDATA     (iDATA),
    .iBLANK    (iBLANK),
    .oDIG      (oDIG),
    .oSEL_N    (oSEL_N),
    .oPEND     (oPEND),
    .oLOAD_ACK (oLOAD_ACK),
    .oFRAME    (oFRAME)
  );

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nErr    = 0;

  // Reference model state
  int          mp;        // position within frame, 0..FRAME-1
  logic [15:0] mAct;
  logic [15:0] mPendVal;
  logic        mPendV;
  logic [3:0]  eSel;
  logic [3:0]  eDig;
  logic        ePend;
  logic        eAck;
  logic        eFrame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mp = 0; mAct = '0; mPendVal = '0; mPendV = 1'b0;
    eSel = 4'hF; eDig = 4'h0; ePend = 1'b0; eAck = 1'b0; eFrame = 1'b0;
  endtask

  task automatic modelEdge(input logic ld, input logic [15:0] d, input logic e,
                           input logic [3:0] b);
    int  slot;
    int  ns;
    logic bnd;
    slot = mp / SLOT;
    bnd  = e && (mp == FRAME - 1);
    if (!e) mp = slot * SLOT;
    else    mp = (mp + 1) % FRAME;
    eFrame = bnd;
    eAck   = 1'b0;
    if (bnd && mPendV) begin
      mAct   = mPendVal;
      mPendV = 1'b0;
      eAck   = 1'b1;
    end
    if (ld) begin
      mPendVal = d;
      mPendV   = 1'b1;
    end
    ePend = mPendV;
    ns    = mp / SLOT;
    if (e && (mp % SLOT) >= BLC && !b[ns]) eSel = ~(4'b0001 << ns);
    else                                   eSel = 4'hF;
    eDig = mAct[ns*4 +: 4];
  endtask

  task automatic compareAll();
    chk("sel_n", {28'd0, oSEL_N}, {28'd0, eSel});
    chk("dig",   {28'd0, oDIG},   {28'd0, eDig});
    chk("pend",  {31'd0, oPEND},  {31'd0, ePend});
    chk("ack",   {31'd0, oLOAD_ACK}, {31'd0, eAck});
    chk("frame", {31'd0, oFRAME}, {31'd0, eFrame});
  endtask

  task automatic tick(input logic ld, input logic [15:0] d, input logic e,
                      input logic [3:0] b);
    iLOAD = ld; iDATA = d; iEN = e; iBLANK = b;
    @(posedge iCLK);
    modelEdge(ld, d, e, b);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n, input logic [3:0] b);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, 1'b1, b);
  endtask

  task automatic runTo(input int pos);
    int g;
    g = 0;
    while (mp != pos && g < 2 * FRAME) begin
      tick(1'b0, 16'h0000, 1'b1, 4'h0);
      g++;
    end
    chk("align_pos", mp, pos);
  endtask

  initial begin
    logic        ld;
    logic        e;
    logic [3:0]  b;
    iRST_N = 1'b0; iEN = 1'b0; iLOAD = 1'b0; iDATA = '0; iBLANK = '0;
    modelReset();
    #12;
    // Reset state
    chk("rst_sel_n", {28'd0, oSEL_N}, 32'hF);
    chk("rst_dig",   {28'd0, oDIG},   32'h0);
    chk("rst_pend",  {31'd0, oPEND},  32'h0);
    chk("rst_ack",   {31'd0, oLOAD_ACK}, 32'h0);
    chk("rst_frame", {31'd0, oFRAME}, 32'h0);
    iRST_N = 1'b1;

    // Plain scanning of all-zero data, a little over one frame
    idle(FRAME + 5, 4'h0);

    // Mid-frame load of 3A7F, then through the boundary and a full frame
    runTo(13);
    tick(1'b1, 16'h3A7F, 1'b1, 4'h0);
    idle(2 * FRAME, 4'h0);

    // Two loads in one frame: latest wins, single ack
    runTo(5);
    tick(1'b1, 16'h1111, 1'b1, 4'h0);
    idle(10, 4'h0);
    tick(1'b1, 16'h2222, 1'b1, 4'h0);
    idle(2 * FRAME, 4'h0);

    // Load coinciding with the frame boundary while another value is pending
    runTo(20);
    tick(1'b1, 16'h1234, 1'b1, 4'h0);
    runTo(FRAME - 1);
    tick(1'b1, 16'h5555, 1'b1, 4'h0);
    chk("bnd_ack_1234", {31'd0, oLOAD_ACK}, 32'h1);
    chk("bnd_pend_5555", {31'd0, oPEND}, 32'h1);
    idle(2 * FRAME, 4'h0);

    // Blank mask 0101 for two frames
    idle(2 * FRAME, 4'b0101);

    // Disable during ON of digit 2, then resume
    runTo(2 * SLOT + 4);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'h0000, 1'b0, 4'h0);
    tick(1'b1, 16'hBEEF, 1'b0, 4'h0);
    idle(FRAME + 10, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 19) != 0);
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      tick(ld, 16'($urandom), e, b);
    end

    // Async reset in the middle of an ON slot with data pending
    runTo(SLOT + 3);
    tick(1'b1, 16'hC0DE, 1'b1, 4'h0);
    chk("pre_rst_pend", {31'd0, oPEND}, 32'h1);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("arst_sel_n", {28'd0, oSEL_N}, 32'hF);
    chk("arst_pend",  {31'd0, oPEND},  32'h0);
    chk("arst_dig",   {28'd0, oDIG},   32'h0);
    modelReset();
    #3;
    iRST_N = 1'b1;
    idle(FRAME + 5, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule
